// File: rtl/tlp_reg_responder_pkg.sv
// -----------------------------------------------------------------------------
// tlp_reg_responder_pkg
// Shared transceiver types for the register-access responder: action pipe
// records (RegRead / RegWrite / ErrorCode overlay), the two-QW completion
// layouts with their generators, the responder FSM states and the data word
// returned when a register read times out.
// -----------------------------------------------------------------------------
package tlp_reg_responder_pkg;

  localparam int REGADDR_NBITS = 10;

  typedef enum logic [1:0] {
    ACT_READ      = 2'd0,
    ACT_WRITE     = 2'd1,
    ACT_ERROR     = 2'd2,
    ACT_RESERVED2 = 2'd3
  } ActType;

  typedef struct packed {
    logic [REGADDR_NBITS-1:0] chan;
    logic [31:0]              data;
  } RegWrite;

  typedef struct packed {
    logic [REGADDR_NBITS-1:0] chan;
    logic [15:0]              reqID;
    logic [7:0]               tag;
    logic [7:0]               rsvd;
  } RegRead;

  typedef struct packed {
    logic [7:0]               code;
    logic [REGADDR_NBITS+23:0] rsvd;
  } ErrorCode;

  // All three payload views share the same 42 bits; typ selects the view.
  typedef union packed {
    RegWrite  wr;
    RegRead   rd;
    ErrorCode err;
  } ActPayload;

  typedef struct packed {
    ActType    typ;
    ActPayload payload;
  } Action;

  typedef enum logic [1:0] {
    H3DW_NODATA   = 2'd0,
    H4DW_NODATA   = 2'd1,
    H3DW_WITHDATA = 2'd2,
    H4DW_WITHDATA = 2'd3
  } TlpFmt;

  typedef enum logic [4:0] {
    MEM_RW     = 5'b00000,
    COMPLETION = 5'b01010
  } TlpType;

  // QW0: header DW1 in the upper half, header DW0 in the lower half.
  typedef struct packed {
    logic [15:0] cmpID;
    logic [2:0]  status;
    logic        bcm;
    logic [11:0] byteCount;
    logic        rsvd0;
    TlpFmt       fmt;
    TlpType      typ;
    logic        rsvd1;
    logic [2:0]  tc;
    logic [3:0]  rsvd2;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [1:0]  rsvd3;
    logic [9:0]  dwCount;
  } Completion0;

  // QW1: payload DW in the upper half, header DW2 in the lower half.
  typedef struct packed {
    logic [31:0] data;
    logic [15:0] reqID;
    logic [7:0]  tag;
    logic [2:0]  rsvd;
    logic [3:0]  lowAddr;
    logic        nonAligned;
  } Completion1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    CMP0    = 2'd2,
    CMP1    = 2'd3
  } RspState;

  localparam logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF;
  localparam logic [11:0] REG_BYTE_COUNT = 12'd4;
  localparam logic [9:0]  REG_DW_COUNT   = 10'd1;

  function automatic Completion0 genRegCmp0(input logic [15:0] cmpID);
    Completion0 c;
    c           = '0;
    c.cmpID     = cmpID;
    c.byteCount = REG_BYTE_COUNT;
    c.fmt       = H3DW_WITHDATA;
    c.typ       = COMPLETION;
    c.dwCount   = REG_DW_COUNT;
    return c;
  endfunction

  function automatic Completion1 genRegCmp1(input logic [31:0] data,
                                            input logic [15:0] reqID,
                                            input logic [7:0]  tag,
                                            input logic [3:0]  lowAddr,
                                            input logic        nonAligned);
    Completion1 c;
    c            = '0;
    c.data       = data;
    c.reqID      = reqID;
    c.tag        = tag;
    c.lowAddr    = lowAddr;
    c.nonAligned = nonAligned;
    return c;
  endfunction

endpackage

// File: rtl/tlp_reg_responder_if.sv
// -----------------------------------------------------------------------------
// tlp_reg_responder_if
// Bundles the responder's three channels:
//   action pipe   : actData_in, actValid_in, actReady_out
//   register file : regWr{Addr,Data,Valid}_out, regRd{Addr,Req}_out,
//                   regRd{Data,Valid}_in
//   TX Avalon-ST  : txData_out, txValid_out, txSOP_out, txEOP_out, txReady_in
// master = responder side, slave = surrounding logic.
// -----------------------------------------------------------------------------
interface tlp_reg_responder_if;
  import tlp_reg_responder_pkg::*;

  Action                    actData_in;
  logic                     actValid_in;
  logic                     actReady_out;
  logic [REGADDR_NBITS-1:0] regWrAddr_out;
  logic [31:0]              regWrData_out;
  logic                     regWrValid_out;
  logic [REGADDR_NBITS-1:0] regRdAddr_out;
  logic                     regRdReq_out;
  logic [31:0]              regRdData_in;
  logic                     regRdValid_in;
  logic [63:0]              txData_out;
  logic                     txValid_out;
  logic                     txSOP_out;
  logic                     txEOP_out;
  logic                     txReady_in;

  modport master (
    input  actData_in, actValid_in, regRdData_in, regRdValid_in, txReady_in,
    output actReady_out, regWrAddr_out, regWrData_out, regWrValid_out,
           regRdAddr_out, regRdReq_out, txData_out, txValid_out, txSOP_out,
           txEOP_out
  );

  modport slave (
    output actData_in, actValid_in, regRdData_in, regRdValid_in, txReady_in,
    input  actReady_out, regWrAddr_out, regWrData_out, regWrValid_out,
           regRdAddr_out, regRdReq_out, txData_out, txValid_out, txSOP_out,
           txEOP_out
  );

endinterface

// File: rtl/tlp_reg_responder.sv
// -----------------------------------------------------------------------------
// tlp_reg_responder
// Serves register actions from the RX->TX action pipe: writes become one-cycle
// register-file strobes, reads are issued to the register file and answered
// with a two-QW completion TLP on the 64-bit TX stream. A read that gets no
// data within TIMEOUT_CYCLES completes with TIMEOUT_DATA and pulses timeout_out.
// Ports:
//   pcieClk_in    : clock, rising edge
//   pcieRst_in    : synchronous active-high reset
//   cfgBusDev_in  : completer ID used in QW0
//   bus           : action / register-file / TX channels (master modport)
//   timeout_out   : one-cycle pulse on read timeout
//   errCount_out  : saturating count of ACT_ERROR / ACT_RESERVED2 actions
// -----------------------------------------------------------------------------
module tlp_reg_responder
  import tlp_reg_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd64
) (
  input  logic                       pcieClk_in,
  input  logic                       pcieRst_in,
  input  logic [15:0]                cfgBusDev_in,
  tlp_reg_responder_if.master        bus,
  output logic                       timeout_out,
  output logic [7:0]                 errCount_out
);

  localparam logic [15:0] TIMEOUT_TERM = 16'(TIMEOUT_CYCLES - 32'd1);

  RspState                  state_r, state_s;
  logic                     ready_r, valid_r, sop_r, eop_r;
  logic                     wr_valid_r, rd_req_r, timeout_r;
  logic [REGADDR_NBITS-1:0] wr_addr_r, rd_chan_r;
  logic [31:0]              wr_data_r, rd_data_r;
  logic [15:0]              rd_req_id_r, cnt_r;
  logic [7:0]               rd_tag_r, err_cnt_r;
  logic                     acc_wr_s, acc_rd_s, acc_err_s;
  logic                     rd_done_s, rd_to_s;
  logic [63:0]              tx_data_s;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_s   = state_r;
    acc_wr_s  = 1'b0;
    acc_rd_s  = 1'b0;
    acc_err_s = 1'b0;
    rd_done_s = 1'b0;
    rd_to_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // ready_r is only ever high in IDLE, so acceptance lives here.
        if (bus.actValid_in && ready_r) begin
          case (bus.actData_in.typ)
            ACT_WRITE: acc_wr_s  = 1'b1;
            ACT_READ:  acc_rd_s  = 1'b1;
            default:   acc_err_s = 1'b1;
          endcase
        end else begin
          acc_wr_s = 1'b0;
        end
        if (acc_rd_s) begin
          state_s = RD_WAIT;
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT: begin
        // Real data takes priority over a coincident timeout.
        if (bus.regRdValid_in) begin
          rd_done_s = 1'b1;
          state_s   = CMP0;
        end else if (cnt_r == TIMEOUT_TERM) begin
          rd_to_s = 1'b1;
          state_s = CMP0;
        end else begin
          state_s = RD_WAIT;
        end
      end
      CMP0: begin
        if (bus.txReady_in) begin
          state_s = CMP1;
        end else begin
          state_s = CMP0;
        end
      end
      CMP1: begin
        if (bus.txReady_in) begin
          state_s = IDLE;
        end else begin
          state_s = CMP1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered handshake flags, strobes, latched read context and counters.
  always_ff @(posedge pcieClk_in) begin
    if (pcieRst_in) begin
      ready_r     <= 1'b0;
      valid_r     <= 1'b0;
      sop_r       <= 1'b0;
      eop_r       <= 1'b0;
      wr_valid_r  <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= 32'd0;
      rd_req_r    <= 1'b0;
      rd_chan_r   <= '0;
      rd_req_id_r <= 16'd0;
      rd_tag_r    <= 8'd0;
      rd_data_r   <= 32'd0;
      cnt_r       <= 16'd0;
      timeout_r   <= 1'b0;
      err_cnt_r   <= 8'd0;
    end else begin
      // Flags follow the next state so they line up with state_r.
      ready_r    <= (state_s == IDLE);
      valid_r    <= (state_s == CMP0) || (state_s == CMP1);
      sop_r      <= (state_s == CMP0);
      eop_r      <= (state_s == CMP1);
      wr_valid_r <= acc_wr_s;
      rd_req_r   <= acc_rd_s;
      timeout_r  <= rd_to_s;
      if (acc_wr_s) begin
        wr_addr_r <= bus.actData_in.payload.wr.chan;
        wr_data_r <= bus.actData_in.payload.wr.data;
      end
      if (acc_rd_s) begin
        rd_chan_r   <= bus.actData_in.payload.rd.chan;
        rd_req_id_r <= bus.actData_in.payload.rd.reqID;
        rd_tag_r    <= bus.actData_in.payload.rd.tag;
        cnt_r       <= 16'd0;
      end else if ((state_r == RD_WAIT) && (cnt_r != TIMEOUT_TERM)) begin
        cnt_r <= cnt_r + 16'd1;
      end
      if (rd_done_s) begin
        rd_data_r <= bus.regRdData_in;
      end else if (rd_to_s) begin
        rd_data_r <= TIMEOUT_DATA;
      end
      if (acc_err_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end
    end
  end

  // TX QW select; QW0 takes the completer ID live, QW1 is built from latched context.
  always_comb begin
    tx_data_s = 64'd0;
    case (state_r)
      CMP0:    tx_data_s = genRegCmp0(cfgBusDev_in);
      CMP1:    tx_data_s = genRegCmp1(rd_data_r, rd_req_id_r, rd_tag_r,
                                      rd_chan_r[4:1], rd_chan_r[0]);
      default: tx_data_s = 64'd0;
    endcase
  end

  assign bus.actReady_out   = ready_r;
  assign bus.regWrAddr_out  = wr_addr_r;
  assign bus.regWrData_out  = wr_data_r;
  assign bus.regWrValid_out = wr_valid_r;
  assign bus.regRdAddr_out  = rd_chan_r;
  assign bus.regRdReq_out   = rd_req_r;
  assign bus.txData_out     = tx_data_s;
  assign bus.txValid_out    = valid_r;
  assign bus.txSOP_out      = sop_r;
  assign bus.txEOP_out      = eop_r;
  assign timeout_out        = timeout_r;
  assign errCount_out       = err_cnt_r;

endmodule

// File: tb/tb_tlp_reg_responder.sv
// -----------------------------------------------------------------------------
// tb_tlp_reg_responder
// Table of directed read/write vectors, randomized actions against a
// transaction-level model, and hand sequences for saturation, reset and
// out-of-state read data.
// -----------------------------------------------------------------------------
module tb_tlp_reg_responder;
  import tlp_reg_responder_pkg::*;

  localparam int TO = 64;
  localparam logic [1:0] T_READ  = 2'd0;
  localparam logic [1:0] T_WRITE = 2'd1;
  localparam logic [1:0] T_ERR   = 2'd2;
  localparam logic [1:0] T_RSV   = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg = 16'h0A10;
  logic        timeout;
  logic [7:0]  errc;

  tlp_reg_responder_if bus_if ();

  tlp_reg_responder #(.TIMEOUT_CYCLES(TO)) dut (
    .pcieClk_in   (clk),
    .pcieRst_in   (rst),
    .cfgBusDev_in (cfg),
    .bus          (bus_if.master),
    .timeout_out  (timeout),
    .errCount_out (errc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  typ;
    logic [9:0]  chan;
    logic [31:0] data;
    logic [15:0] reqid;
    logic [7:0]  tag;
    int          lat;      // RD_WAIT cycle carrying regRdValid_in (-1: never)
    int          s0;       // cycles txReady_in held low in front of QW0
    int          s1;       // cycles txReady_in held low in front of QW1
    logic [31:0] exp_data; // expected completion payload
    logic        exp_to;   // expected timeout pulse
  } vec_t;

  int checks = 0;
  int errors = 0;
  int err_model = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // QW0 as header DW1 (upper) : DW0 (lower); DW0 top byte 0_10_01010 = 0x4A.
  function automatic logic [63:0] exp_qw0(logic [15:0] id);
    logic [31:0] dw0;
    logic [31:0] dw1;
    dw0 = 32'h4A00_0001;
    dw1 = {id, 4'h0, 12'd4};
    return {dw1, dw0};
  endfunction

  function automatic logic [63:0] exp_qw1(logic [31:0] d, logic [15:0] rid,
                                          logic [7:0] tg, logic [9:0] ch);
    logic [3:0] low_addr;
    logic       non_al;
    low_addr = ch[4:1];
    non_al   = ch[0];
    return {d, rid, tg, 3'b000, low_addr, non_al};
  endfunction

  task automatic chk_all_zero(string tag);
    chk({tag, "_act_ready"}, 64'(bus_if.actReady_out), 64'd0);
    chk({tag, "_wr_valid"},  64'(bus_if.regWrValid_out), 64'd0);
    chk({tag, "_wr_addr"},   64'(bus_if.regWrAddr_out), 64'd0);
    chk({tag, "_wr_data"},   64'(bus_if.regWrData_out), 64'd0);
    chk({tag, "_rd_addr"},   64'(bus_if.regRdAddr_out), 64'd0);
    chk({tag, "_rd_req"},    64'(bus_if.regRdReq_out), 64'd0);
    chk({tag, "_tx_data"},   bus_if.txData_out, 64'd0);
    chk({tag, "_tx_valid"},  64'(bus_if.txValid_out), 64'd0);
    chk({tag, "_tx_sop"},    64'(bus_if.txSOP_out), 64'd0);
    chk({tag, "_tx_eop"},    64'(bus_if.txEOP_out), 64'd0);
    chk({tag, "_timeout"},   64'(timeout), 64'd0);
    chk({tag, "_err_count"}, 64'(errc), 64'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus_if.actReady_out !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("act_ready_wait", 64'(bus_if.actReady_out), 64'd1);
  endtask

  task automatic do_write(input vec_t v);
    wait_ready();
    bus_if.actData_in  = Action'({T_WRITE, v.chan, v.data});
    bus_if.actValid_in = 1'b1;
    step();
    bus_if.actValid_in = 1'b0;
    chk("wr_strobe", 64'(bus_if.regWrValid_out), 64'd1);
    chk("wr_addr", 64'(bus_if.regWrAddr_out), 64'(v.chan));
    chk("wr_data", 64'(bus_if.regWrData_out), 64'(v.data));
    chk("wr_no_tx", 64'(bus_if.txValid_out), 64'd0);
    chk("wr_no_rd_req", 64'(bus_if.regRdReq_out), 64'd0);
    step();
    chk("wr_strobe_end", 64'(bus_if.regWrValid_out), 64'd0);
  endtask

  task automatic do_err(input logic [1:0] typ);
    logic [41:0] junk;
    junk = {10'($urandom), 32'($urandom)};
    wait_ready();
    bus_if.actData_in  = Action'({typ, junk});
    bus_if.actValid_in = 1'b1;
    step();
    bus_if.actValid_in = 1'b0;
    err_model = (err_model >= 255) ? 255 : err_model + 1;
    chk("err_count", 64'(errc), 64'(err_model));
    chk("err_no_wr", 64'(bus_if.regWrValid_out), 64'd0);
    chk("err_no_rd", 64'(bus_if.regRdReq_out), 64'd0);
  endtask

  task automatic do_read(input vec_t v);
    int k_exit;
    int cyc;
    int to_seen;
    int beats;
    int held;
    logic rdy;
    k_exit = v.exp_to ? TO - 1 : v.lat;
    wait_ready();
    bus_if.actData_in  = Action'({T_READ, v.chan, v.reqid, v.tag, 8'h00});
    bus_if.actValid_in = 1'b1;
    step();
    bus_if.actValid_in = 1'b0;
    cyc     = 0;
    to_seen = 0;
    chk("rd_req", 64'(bus_if.regRdReq_out), 64'd1);
    chk("rd_addr", 64'(bus_if.regRdAddr_out), 64'(v.chan));
    chk("rd_busy", 64'(bus_if.actReady_out), 64'd0);
    for (int k = 0; k < TO + 8; k++) begin
      if (k == v.lat) begin
        bus_if.regRdValid_in = 1'b1;
        bus_if.regRdData_in  = v.data;
      end else begin
        bus_if.regRdValid_in = 1'b0;
        bus_if.regRdData_in  = $urandom;
      end
      step();
      cyc++;
      bus_if.regRdValid_in = 1'b0;
      if (timeout === 1'b1) to_seen++;
      if (k == 0) chk("rd_req_pulse", 64'(bus_if.regRdReq_out), 64'd0);
      if (bus_if.txValid_out === 1'b1) begin
        chk("rd_exit_cycle", 64'(k), 64'(k_exit));
        break;
      end
    end
    chk("cmp_started", 64'(bus_if.txValid_out), 64'd1);
    beats = 0;
    held  = 0;
    for (int n = 0; n < 40 && beats < 2; n++) begin
      chk("tx_valid", 64'(bus_if.txValid_out), 64'd1);
      chk("tx_busy", 64'(bus_if.actReady_out), 64'd0);
      if (beats == 0) begin
        chk("qw0_data", bus_if.txData_out, exp_qw0(cfg));
        chk("qw0_sop", 64'(bus_if.txSOP_out), 64'd1);
        chk("qw0_eop", 64'(bus_if.txEOP_out), 64'd0);
        rdy = (held >= v.s0);
      end else begin
        chk("qw1_data", bus_if.txData_out, exp_qw1(v.exp_data, v.reqid, v.tag, v.chan));
        chk("qw1_sop", 64'(bus_if.txSOP_out), 64'd0);
        chk("qw1_eop", 64'(bus_if.txEOP_out), 64'd1);
        rdy = (held >= v.s1);
      end
      bus_if.txReady_in = rdy;
      step();
      cyc++;
      if (rdy) begin
        beats++;
        held = 0;
      end else begin
        held++;
      end
      if (timeout === 1'b1) to_seen++;
    end
    bus_if.txReady_in = 1'b0;
    chk("tx_beats", 64'(beats), 64'd2);
    chk("tx_done_idle", 64'(bus_if.txValid_out), 64'd0);
    chk("rd_ready_again", 64'(bus_if.actReady_out), 64'd1);
    chk("timeout_pulses", 64'(to_seen), 64'(v.exp_to));
    chk("round_trip_cycles", 64'(cyc), 64'((k_exit + 1) + (v.s0 + 1) + (v.s1 + 1)));
  endtask

  vec_t tbl[8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   r;
    bus_if.actData_in    = '0;
    bus_if.actValid_in   = 1'b0;
    bus_if.regRdData_in  = 32'd0;
    bus_if.regRdValid_in = 1'b0;
    bus_if.txReady_in    = 1'b0;

    tbl[0] = '{T_WRITE, 10'h005, 32'h12345678, 16'h0000, 8'h00,  0, 0, 0, 32'h0, 1'b0};
    tbl[1] = '{T_READ,  10'h003, 32'hCAFEBABE, 16'h0100, 8'h2A,  2, 0, 0, 32'hCAFEBABE, 1'b0};
    tbl[2] = '{T_READ,  10'h003, 32'hCAFEBABE, 16'h0100, 8'h2A, -1, 0, 0, 32'hDEADBEEF, 1'b1};
    tbl[3] = '{T_READ,  10'h003, 32'h0BADF00D, 16'h0100, 8'h2A,  2, 5, 3, 32'h0BADF00D, 1'b0};
    tbl[4] = '{T_READ,  10'h010, 32'h11112222, 16'hFFFF, 8'hFF,  1, 0, 0, 32'h11112222, 1'b0};
    tbl[5] = '{T_READ,  10'h3FF, 32'hA5A5A5A5, 16'h1357, 8'h01, TO - 1, 1, 0, 32'hA5A5A5A5, 1'b0};
    tbl[6] = '{T_READ,  10'h00E, 32'h5555AAAA, 16'h0042, 8'h80,  0, 0, 2, 32'h5555AAAA, 1'b0};
    tbl[7] = '{T_WRITE, 10'h3FF, 32'hFFFFFFFF, 16'h0000, 8'h00,  0, 0, 0, 32'h0, 1'b0};

    // Power-on reset.
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk("ready_after_reset", 64'(bus_if.actReady_out), 64'd1);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].typ == T_WRITE) do_write(tbl[i]);
      else do_read(tbl[i]);
    end

    // Read data while idle must be ignored.
    bus_if.regRdValid_in = 1'b1;
    bus_if.regRdData_in  = 32'h01234567;
    step();
    bus_if.regRdValid_in = 1'b0;
    step();
    chk("stray_rd_no_tx", 64'(bus_if.txValid_out), 64'd0);
    chk("stray_rd_ready", 64'(bus_if.actReady_out), 64'd1);

    // Randomized actions against the transaction model.
    for (int i = 0; i < 40; i++) begin
      r        = $urandom_range(0, 2);
      v.chan   = 10'($urandom);
      v.data   = $urandom;
      v.reqid  = 16'($urandom);
      v.tag    = 8'($urandom);
      v.s0     = $urandom_range(0, 3);
      v.s1     = $urandom_range(0, 3);
      v.lat    = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(0, 6);
      v.exp_to = (v.lat < 0) || (v.lat >= TO);
      v.exp_data = v.exp_to ? 32'hDEADBEEF : v.data;
      if (r == 0) begin
        v.typ = T_WRITE;
        do_write(v);
      end else if (r == 1) begin
        v.typ = T_READ;
        do_read(v);
      end else begin
        do_err(($urandom_range(0, 1) == 0) ? T_ERR : T_RSV);
      end
    end

    // 300 back-to-back error actions saturate the counter.
    wait_ready();
    bus_if.actData_in  = Action'({T_ERR, 42'd0});
    bus_if.actValid_in = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      err_model = (err_model >= 255) ? 255 : err_model + 1;
      chk("err_sat_step", 64'(errc), 64'(err_model));
    end
    bus_if.actValid_in = 1'b0;
    chk("err_saturated", 64'(errc), 64'd255);
    rst = 1'b1;
    step();
    rst = 1'b0;
    err_model = 0;
    chk_all_zero("err_reset");
    step();

    // Reset in the middle of CMP1 drops the packet.
    wait_ready();
    bus_if.actData_in  = Action'({T_READ, 10'h007, 16'h1234, 8'h55, 8'h00});
    bus_if.actValid_in = 1'b1;
    step();
    bus_if.actValid_in   = 1'b0;
    bus_if.regRdValid_in = 1'b1;
    bus_if.regRdData_in  = 32'h77778888;
    step();
    bus_if.regRdValid_in = 1'b0;
    chk("mid_sop", 64'(bus_if.txSOP_out), 64'd1);
    bus_if.txReady_in = 1'b1;
    step();
    bus_if.txReady_in = 1'b0;
    chk("mid_eop", 64'(bus_if.txEOP_out), 64'd1);
    chk("mid_qw1", bus_if.txData_out, exp_qw1(32'h77778888, 16'h1234, 8'h55, 10'h007));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all_zero("cmp1_reset");
    bus_if.txReady_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_eop_after_reset", 64'(bus_if.txValid_out), 64'd0);
    end
    bus_if.txReady_in = 1'b0;
    v = '{T_READ, 10'h00B, 32'h600DF00D, 16'h0203, 8'h04, 3, 0, 0, 32'h600DF00D, 1'b0};
    do_read(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
